// File: rtl/mem_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : mem_burst_reader
//  Purpose  : Flop-based 2**AW x DW memory with a synchronous write port and
//             a burst read sequencer that streams a contiguous, wrap-around
//             address range through a registered valid/ready output.
//  Ports    : clk, rst                - clock, synchronous active-high reset
//             wr_en/wr_addr/wr_data   - write port, legal in any state
//             start/base/count        - burst request, sampled in IDLE only
//             busy                    - burst in progress (READ state)
//             out_valid/out_data      - registered output word
//             out_ready               - consumer handshake
//             done                    - one-cycle pulse when a burst finishes
//  Revision : 1.0  initial release
// ============================================================================
module mem_burst_reader #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          out_valid,
  output logic [DW-1:0] out_data,
  input  logic          out_ready,
  output logic          done
);

  localparam int DEPTH = 2**AW;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t          r_state;
  logic [DW-1:0]   r_mem [DEPTH];
  logic [AW-1:0]   r_rd_addr;
  logic [AW:0]     r_remaining;
  logic            r_busy;
  logic            r_out_valid;
  logic [DW-1:0]   r_out_data;
  logic            r_done;

  logic [DW-1:0]   w_rd_word;
  logic            w_slot_free;

  // Asynchronous read; a same-edge write is not yet visible here, so a load
  // colliding with a write captures the old contents.
  assign w_rd_word   = r_mem[r_rd_addr];
  // The output register can take a new word if empty or being drained now.
  assign w_slot_free = !r_out_valid || out_ready;

  // Memory array: no reset, writes accepted regardless of rst or state.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      r_mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_rd_addr   <= '0;
      r_remaining <= '0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_done      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_rd_addr   <= base;
            r_remaining <= count;
            r_busy      <= 1'b1;
            r_state     <= S_READ;
          end
        end

        S_READ: begin
          if (r_remaining != '0) begin
            if (w_slot_free) begin
              r_out_data  <= w_rd_word;
              r_out_valid <= 1'b1;
              r_rd_addr   <= r_rd_addr + 1'b1;
              r_remaining <= r_remaining - 1'b1;
            end
          end else if (w_slot_free) begin
            // Last word (if any) drained: finish the burst.
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
            r_state     <= S_FIN;
          end
        end

        S_FIN: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end

        default: begin
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
          r_done      <= 1'b0;
          r_state     <= S_IDLE;
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign done      = r_done;

endmodule
`default_nettype wire

// File: tb/tb_mem_burst_reader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_burst_reader
//  Purpose  : Directed self-checking bench for mem_burst_reader.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_burst_reader;

  localparam int AW = 4;
  localparam int DW = 8;

  logic          clk;
  logic          rst;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic          busy;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
  logic          done;

  logic [DW-1:0] model [16];

  int n_total;
  int n_bad;

  mem_burst_reader #(.AW(AW), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .start     (start),
    .base      (base),
    .count     (count),
    .busy      (busy),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    if (obs !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; sampling and driving happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
    model[a] = d;
  endtask

  // Burst with out_ready held high, checked cycle by cycle against the model.
  task automatic do_burst(input logic [AW-1:0] b, input int n, input string nm);
    logic [AW-1:0] a;
    out_ready = 1'b1;
    start = 1'b1;
    base  = b;
    count = n[AW:0];
    tick();
    start = 1'b0;
    check({nm, "_busy"},  busy, 1);
    check({nm, "_v0"},    out_valid, 0);
    for (int i = 0; i < n; i++) begin
      tick();
      a = b + i[AW-1:0];
      check({nm, "_valid"}, out_valid, 1);
      check({nm, "_data"},  out_data, model[a]);
      check({nm, "_nodone"}, done, 0);
    end
    tick();
    check({nm, "_done"},     done, 1);
    check({nm, "_finbusy"},  busy, 0);
    check({nm, "_finvalid"}, out_valid, 0);
    tick();
    check({nm, "_done_off"}, done, 0);
    check({nm, "_idle"},     busy, 0);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    start     = 1'b0;
    base      = '0;
    count     = '0;
    out_ready = 1'b1;
    for (int i = 0; i < 16; i++) model[i] = 8'h00;

    #1;
    tick();
    tick();
    check("rst_busy",  busy, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data",  out_data, 0);
    check("rst_done",  done, 0);
    rst = 1'b0;
    tick();

    // Fill and full-depth burst
    for (int i = 0; i < 16; i++) wr(i[AW-1:0], 8'hA0 + i[7:0]);
    do_burst(4'd0, 16, "fill");

    // Wrap-around
    do_burst(4'd14, 4, "wrap");

    // Backpressure: base=3 count=3, stall 3 cycles on the first word
    start = 1'b1; base = 4'd3; count = 5'd3;
    tick();
    start = 1'b0;
    tick();
    check("bp_first_valid", out_valid, 1);
    check("bp_first_data",  out_data, 8'hA3);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_hold_valid", out_valid, 1);
      check("bp_hold_data",  out_data, 8'hA3);
    end
    out_ready = 1'b1;
    tick();
    check("bp_w1", out_data, 8'hA4);
    tick();
    check("bp_w2", out_data, 8'hA5);
    check("bp_w2_nodone", done, 0);
    tick();
    check("bp_done", done, 1);
    check("bp_fin_valid", out_valid, 0);
    tick();
    check("bp_done_off", done, 0);

    // count = 0
    do_burst(4'd7, 0, "zero");

    // start held through a burst and its FIN cycle has no effect
    start = 1'b1; base = 4'd0; count = 5'd4;
    tick();
    base = 4'd9; count = 5'd2;
    check("ign_busy", busy, 1);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("ign_data", out_data, 8'hA0 + i[7:0]);
    end
    tick();
    check("ign_done", done, 1);
    tick();
    start = 1'b0;
    check("ign_fin_start", busy, 0);
    check("ign_done_off", done, 0);
    tick();
    check("ign_still_idle", busy, 0);

    // Collision: write mem[5] on the same edge that loads address 5
    start = 1'b1; base = 4'd5; count = 5'd2;
    tick();
    start = 1'b0;
    wr_en = 1'b1; wr_addr = 4'd5; wr_data = 8'h55;
    tick();
    wr_en = 1'b0;
    check("col_old", out_data, 8'hA5);
    model[5] = 8'h55;
    tick();
    check("col_next", out_data, 8'hA6);
    tick();
    check("col_done", done, 1);
    tick();
    do_burst(4'd5, 1, "col_new");
    check("col_new_model", model[5], 8'h55);

    // Reset mid-burst after the second word
    start = 1'b1; base = 4'd0; count = 5'd8;
    tick();
    start = 1'b0;
    tick();
    tick();
    check("mr_second", out_data, 8'hA1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mr_busy",  busy, 0);
    check("mr_valid", out_valid, 0);
    check("mr_data",  out_data, 0);
    check("mr_done",  done, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("mr_nodone", done, 0);
      check("mr_novalid", out_valid, 0);
    end
    do_burst(4'd0, 16, "after_rst");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
